// File: rtl/dcache_ctrl_if.sv
// Bundles the MEM-stage request bus and the backing-memory bus of the data cache.
interface dcache_ctrl_if;
  // pipeline side
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_rd;
  logic        req_wr;
  logic [15:0] rdata;
  logic        done;
  logic        stall;
  logic        hit;
  logic        err;
  // backing-memory side
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  // cache view
  modport slave (
    input  req_addr, req_wdata, req_rd, req_wr, mem_rdata, mem_ack,
    output rdata, done, stall, hit, err, mem_addr, mem_wdata, mem_rd, mem_wr
  );

  // environment view (pipeline + memory)
  modport master (
    output req_addr, req_wdata, req_rd, req_wr, mem_rdata, mem_ack,
    input  rdata, done, stall, hit, err, mem_addr, mem_wdata, mem_rd, mem_wr
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage.
// Lines hold 4 16-bit words; read hits answer combinationally, misses fill the
// whole line in word order 0..3, every store is written through to memory.
module dcache_ctrl #(
  parameter int unsigned INDEX_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  dcache_ctrl_if.slave  bus
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned TAG_W = 13 - INDEX_W;

  typedef enum logic [1:0] {IDLE, FILL, RESP, WRITE} state_t;

  state_t               state_q;
  logic [15:1]          addr_q;
  logic [1:0]           cnt_q;
  logic                 whit_q;
  logic [LINES-1:0]     valid_q;
  logic [15:1]          mem_addr_q;
  logic [15:0]          mem_wdata_q;
  logic                 mem_rd_q;
  logic                 mem_wr_q;

  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [15:0]          data_q [LINES][4];

  logic [INDEX_W-1:0]   req_idx;
  logic [TAG_W-1:0]     req_tag;
  logic [1:0]           req_word;
  logic [INDEX_W-1:0]   lat_idx;
  logic [TAG_W-1:0]     lat_tag;
  logic [1:0]           lat_word;

  logic                 in_idle;
  logic                 lookup_hit;
  logic                 req_any;
  logic                 req_bad;
  logic                 ack_bad;
  logic                 req_ok;
  logic                 rd_hit;
  logic                 rd_miss;
  logic                 wr_go;
  logic                 fill_we;
  logic                 fill_last;

  assign req_idx  = bus.req_addr[INDEX_W+2:3];
  assign req_tag  = bus.req_addr[15:INDEX_W+3];
  assign req_word = bus.req_addr[2:1];
  assign lat_idx  = addr_q[INDEX_W+2:3];
  assign lat_tag  = addr_q[15:INDEX_W+3];
  assign lat_word = addr_q[2:1];

  // Request decode, lookup and the combinational pipeline-side outputs.
  // A stray ack in IDLE also drops any request of that cycle, so an err cycle
  // never starts a transaction.
  always_comb begin
    in_idle    = (state_q == IDLE);
    lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    req_any    = bus.req_rd || bus.req_wr;
    req_bad    = in_idle && req_any && ((bus.req_rd && bus.req_wr) || bus.req_addr[0]);
    ack_bad    = bus.mem_ack && (in_idle || (state_q == RESP));
    req_ok     = in_idle && req_any && !req_bad && !bus.mem_ack;
    rd_hit     = req_ok && bus.req_rd && lookup_hit;
    rd_miss    = req_ok && bus.req_rd && !lookup_hit;
    wr_go      = req_ok && bus.req_wr;
    fill_we    = (state_q == FILL) && bus.mem_ack;
    fill_last  = fill_we && (cnt_q == 2'd3);

    bus.err   = rst && (req_bad || ack_bad);
    bus.done  = rst && (rd_hit || (state_q == RESP) || ((state_q == WRITE) && bus.mem_ack));
    bus.hit   = rst && (rd_hit || ((state_q == WRITE) && bus.mem_ack && whit_q));
    bus.stall = rst && ((state_q == FILL) || ((state_q == WRITE) && !bus.mem_ack) ||
                        rd_miss || wr_go);
    bus.rdata = '0;
    if (rst && rd_hit) begin
      bus.rdata = data_q[req_idx][req_word];
    end else if (rst && (state_q == RESP)) begin
      bus.rdata = data_q[lat_idx][lat_word];
    end
  end

  assign bus.mem_addr  = {mem_addr_q, 1'b0};
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;

  // Control FSM with registered memory-side outputs and the line valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      whit_q      <= 1'b0;
      valid_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_miss) begin
            // The line being refilled is invalid until its last word lands.
            addr_q           <= bus.req_addr[15:1];
            cnt_q            <= '0;
            valid_q[req_idx] <= 1'b0;
            mem_addr_q       <= {bus.req_addr[15:3], 2'b00};
            mem_rd_q         <= 1'b1;
            state_q          <= FILL;
          end else if (wr_go) begin
            addr_q      <= bus.req_addr[15:1];
            whit_q      <= lookup_hit;
            mem_addr_q  <= bus.req_addr[15:1];
            mem_wdata_q <= bus.req_wdata;
            mem_wr_q    <= 1'b1;
            state_q     <= WRITE;
          end
        end
        FILL: begin
          if (bus.mem_ack) begin
            cnt_q           <= cnt_q + 2'd1;
            mem_addr_q[2:1] <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              valid_q[lat_idx] <= 1'b1;
              mem_rd_q         <= 1'b0;
              state_q          <= RESP;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        WRITE: begin
          if (bus.mem_ack) begin
            mem_wr_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data arrays: fill writes from memory, write-hit updates from the pipeline.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[lat_idx][cnt_q] <= bus.mem_rdata;
    end
    if (fill_last) begin
      tag_q[lat_idx] <= lat_tag;
    end
    if (wr_go && lookup_hit) begin
      data_q[req_idx][req_word] <= bus.req_wdata;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a fixed-latency backing-memory responder.
module tb_dcache_ctrl;

  localparam int LAT = 2;

  logic clk;
  logic rst;
  logic resp_ack;
  logic stray_ack;

  int checks;
  int failures;
  int wcnt;

  logic [15:0] wmem [int];
  logic [15:0] rd_log [$];
  logic [31:0] wr_log [$];

  dcache_ctrl_if bus ();

  assign bus.mem_ack = resp_ack | stray_ack;

  dcache_ctrl #(.INDEX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory: acks LAT cycles after each new access is presented, logs traffic.
  initial begin
    logic [15:0] a;
    resp_ack      = 1'b0;
    bus.mem_rdata = '0;
    wcnt          = 0;
    forever begin
      @(posedge clk);
      #1;
      resp_ack = 1'b0;
      if (rst && (bus.mem_rd || bus.mem_wr)) begin
        if (wcnt == LAT) begin
          wcnt     = 0;
          resp_ack = 1'b1;
          a        = bus.mem_addr;
          if (bus.mem_rd) begin
            bus.mem_rdata = wmem.exists(int'(a)) ? wmem[int'(a)] : (16'hA000 + {14'd0, a[2:1]});
            rd_log.push_back(a);
          end else begin
            wmem[int'(a)] = bus.mem_wdata;
            wr_log.push_back({a, bus.mem_wdata});
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Called at edge+1; returns at edge+1 with the request dropped.
  task automatic do_read(input logic [15:0] a, input logic [15:0] exp_d,
                         input logic exp_hit, input int exp_lat, input string tag);
    int lat;
    logic [15:0] base;
    lat  = 0;
    base = a & 16'hFFF8;
    rd_log.delete();
    bus.req_addr = a;
    bus.req_rd   = 1'b1;
    bus.req_wr   = 1'b0;
    #1;
    chk({tag, "_stall0"}, {31'd0, bus.stall}, {31'd0, ~exp_hit});
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #2;
      lat++;
    end
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rdata"}, {16'd0, bus.rdata}, {16'd0, exp_d});
    chk({tag, "_hit"}, {31'd0, bus.hit}, {31'd0, exp_hit});
    chk({tag, "_stall_done"}, {31'd0, bus.stall}, 32'd0);
    if (exp_hit) begin
      chk({tag, "_nrd"}, rd_log.size(), 0);
    end else begin
      chk({tag, "_nrd"}, rd_log.size(), 4);
      for (int i = 0; i < 4; i++) begin
        chk({tag, "_rdaddr"}, {16'd0, (rd_log.size() > i) ? rd_log[i] : 16'hxxxx},
            {16'd0, base + 16'(2 * i)});
      end
    end
    @(posedge clk);
    #1;
    bus.req_rd = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d,
                          input logic exp_hit, input string tag);
    int lat;
    lat = 0;
    rd_log.delete();
    wr_log.delete();
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wr    = 1'b1;
    bus.req_rd    = 1'b0;
    #1;
    chk({tag, "_stall0"}, {31'd0, bus.stall}, 32'd1);
    while (bus.done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #2;
      lat++;
    end
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_hit"}, {31'd0, bus.hit}, {31'd0, exp_hit});
    chk({tag, "_nwr"}, wr_log.size(), 1);
    chk({tag, "_wr"}, (wr_log.size() > 0) ? wr_log[0] : 32'hxxxxxxxx, {a, d});
    chk({tag, "_nrd"}, rd_log.size(), 0);
    @(posedge clk);
    #1;
    bus.req_wr = 1'b0;
  endtask

  initial begin
    int lat;
    checks        = 0;
    failures      = 0;
    clk           = 1'b0;
    rst           = 1'b0;
    stray_ack     = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_rd    = 1'b0;
    bus.req_wr    = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("rst_err", {31'd0, bus.err}, 32'd0);
    chk("rst_hit", {31'd0, bus.hit}, 32'd0);
    chk("rst_memrd", {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_memwr", {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_memaddr", {16'd0, bus.mem_addr}, 32'd0);
    chk("rst_rdata", {16'd0, bus.rdata}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // cold miss, then hits on the filled line
    do_read(16'h0010, 16'hA000, 1'b0, 13, "t1_miss");
    do_read(16'h0012, 16'hA001, 1'b1, 0, "t2_hit");

    // write hit updates cache and memory
    do_write(16'h0014, 16'h1234, 1'b1, "t3_wr");
    do_read(16'h0014, 16'h1234, 1'b1, 0, "t3_rd");

    // write miss does not allocate
    do_write(16'h0200, 16'h5678, 1'b0, "t4_wr");
    do_read(16'h0200, 16'h5678, 1'b0, 13, "t4_rd");

    // conflict miss evicts line at index 2
    do_read(16'h0090, 16'hA000, 1'b0, 13, "t5_evict");
    do_read(16'h0010, 16'hA000, 1'b0, 13, "t5_remiss");
    do_read(16'h0014, 16'h1234, 1'b1, 0, "t5_wt");

    // misaligned request
    rd_log.delete();
    bus.req_addr = 16'h0011;
    bus.req_rd   = 1'b1;
    #1;
    chk("t6_odd_err", {31'd0, bus.err}, 32'd1);
    chk("t6_odd_stall", {31'd0, bus.stall}, 32'd0);
    chk("t6_odd_done", {31'd0, bus.done}, 32'd0);
    @(posedge clk);
    #1;
    bus.req_rd = 1'b0;
    #1;
    chk("t6_odd_memrd", {31'd0, bus.mem_rd}, 32'd0);

    // simultaneous read and write on a cached address
    bus.req_addr = 16'h0012;
    bus.req_rd   = 1'b1;
    bus.req_wr   = 1'b1;
    #1;
    chk("t6_rw_err", {31'd0, bus.err}, 32'd1);
    chk("t6_rw_done", {31'd0, bus.done}, 32'd0);
    chk("t6_rw_hit", {31'd0, bus.hit}, 32'd0);
    chk("t6_rw_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clk);
    #1;
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
    #1;
    chk("t6_rw_memwr", {31'd0, bus.mem_wr}, 32'd0);
    chk("t6_rw_nrd", rd_log.size(), 0);

    // stray ack in IDLE
    @(posedge clk);
    #1;
    stray_ack = 1'b1;
    #1;
    chk("t6_ack_err", {31'd0, bus.err}, 32'd1);
    chk("t6_ack_done", {31'd0, bus.done}, 32'd0);
    @(posedge clk);
    #1;
    stray_ack = 1'b0;
    #1;
    chk("t6_ack_idle", {31'd0, bus.stall | bus.mem_rd | bus.mem_wr}, 32'd0);

    // reset after the second fill ack
    rd_log.delete();
    lat          = 0;
    bus.req_addr = 16'h0030;
    bus.req_rd   = 1'b1;
    while (rd_log.size() < 2 && lat < 100) begin
      @(posedge clk);
      #2;
      lat++;
    end
    chk("t6_rst_acks", rd_log.size(), 2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_rst_memrd", {31'd0, bus.mem_rd}, 32'd0);
    chk("t6_rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("t6_rst_done", {31'd0, bus.done}, 32'd0);
    chk("t6_rst_memaddr", {16'd0, bus.mem_addr}, 32'd0);
    bus.req_rd = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    do_read(16'h0030, 16'hA000, 1'b0, 13, "t6_refill");
    do_read(16'h0036, 16'hA003, 1'b1, 0, "t6_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
